// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: WIDTH-bit operands are pushed through one
// shared 4-bit carry-lookahead slice, one nibble per clock, carry held between nibbles.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead terms; c3 (carry into bit 3) is exported for signed overflow.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : gen_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        nib_s;
  logic              nib_co;
  logic              nib_c3;
  logic              last;

  // Select the current nibble of each latched operand for the shared slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx == IDXW'(n)) begin
        nib_a = opa[4*n +: 4];
        nib_b = opb[4*n +: 4];
      end
    end
  end

  assign last = (idx == IDXW'(NIB - 1));

  cla4 u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co),
    .c3 (nib_c3)
  );

  // Subtraction is A + ~B + 1, so the inversion and forced carry happen at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= in1;
            opb   <= sub ? ~in2 : in2;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          for (int n = 0; n < NIB; n++) begin
            if (idx == IDXW'(n)) begin
              sum[4*n +: 4] <= nib_s;
            end
          end
          carry <= nib_co;
          idx   <= idx + IDXW'(1);
          if (last) begin
            cout  <= nib_co;
            ovf   <= nib_c3 ^ nib_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds WIDTH-bit operands four bits per cycle through one 4-bit carry-lookahead adder slice, with the carry held in a register between nibbles.
- Trades latency for area. Sits between a requesting datapath (start/done handshake) and the shared 4-bit adder slice.
- Supports add and two's-complement subtract. Reports unsigned carry/borrow and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. Elaboration fails otherwise.
- NIB, WIDTH/4, derived nibble count. Not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse. Sampled only when idle or done.
- sub  input  1  0 = in1+in2+cin; 1 = in1-in2. Sampled with start.
- in1  input  WIDTH  operand A. Sampled with start.
- in2  input  WIDTH  operand B. Sampled with start.
- cin  input  1  carry-in for add. Ignored when sub=1.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result. Held until the next accepted start.
- cout  output  1  carry out of the MSB. For sub: 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, nibble index=0, carry register=0.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1:
  - Latch A=in1 and B = sub ? ~in2 : in2.
  - Carry register c = sub ? 1 : cin.
  - Index = 0. Go to RUN. busy=1 from the next cycle.
- RUN, every cycle:
  - The slice adds A[4*idx+3:4*idx] + B[4*idx+3:4*idx] + c.
  - The 4-bit result is written to sum[4*idx+3:4*idx]. c takes the slice carry-out. idx increments.
  - At idx=NIB-1, additionally:
    - cout = slice carry-out.
    - ovf = (carry into bit 3 of the slice) XOR (slice carry-out).
    - Go to DONE.
- Sum nibbles are written progressively. The upper sum bits are undefined-to-requester until done. In the implementation they retain their previous value.
- DONE, one cycle:
  - done=1, busy=0. sum, cout and ovf stable.
  - If start=1, a new operation is accepted exactly as from IDLE (back-to-back), going to RUN. Otherwise go to IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+NIB. This is NIB cycles of busy, then 1 cycle of done. Throughput is one operation per NIB+1 cycles.
- start while RUN: ignored, no effect on operands or state. The requester must hold or re-issue start.
- Operand inputs may change freely after the start edge. Latched copies are used.
- sum/cout/ovf hold after DONE through IDLE until the first RUN nibble write of the next operation. cout and ovf update only at the final nibble.
- Overflow is computed from the MSB nibble only, using the slice's internal bit-3 carry.
- Subtract: sum = in1 - in2 mod 2^WIDTH. cout=0 signals borrow (in1 < in2 unsigned).
- WIDTH=4: NIB=1. One RUN cycle, then DONE.
- rst asserted mid-RUN: the operation is abandoned immediately. All outputs go to reset values, with no done pulse.
- Simultaneous rst and start: reset wins.

Test Plan (WIDTH=16):
- Add: start, in1=0x1234, in2=0x4321, cin=0 -> busy high 4 cycles, then done=1 with sum=0x5555, cout=0, ovf=0.
- Carry ripple across nibbles: in1=0xFFFF, in2=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also in1=0xFFFF, in2=0x0000, cin=1 -> sum=0x0000, cout=1.
- Signed overflow: in1=0x7FFF, in2=0x0001 -> sum=0x8000, cout=0, ovf=1. Also in1=0x8000, in2=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract: sub=1, in1=0x0005, in2=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0 (borrow), ovf=0. Also sub=1, in1=0x8000, in2=0x0001 -> sum=0x7FFF, ovf=1.
- Handshake: start pulsed again 2 cycles into RUN with different operands -> ignored, original result delivered. start held high during the DONE cycle with in1=0x0001, in2=0x0002 -> accepted, done again NIB+1 cycles later with sum=0x0003.
- Reset mid-op: start 0x1234+0x4321, assert rst after 2 RUN cycles -> busy, done, sum, cout and ovf all 0 asynchronously. After release, a new start gives the correct result.
